// File: rtl/simon_64_96.sv
// simon_64_96: iterative SIMON 64/96 core, one round per clock, with a stored round-key table
module simon_64_96 #(
    parameter int N  = 32,
    parameter int M  = 3,
    parameter int T  = 42,
    parameter int Co = 6
) (
    input  logic                clk,
    input  logic                nR,
    input  logic                newKey,
    input  logic [M-1:0][N-1:0] key,
    input  logic                newData,
    input  logic [2*N-1:0]      plain,
    input  logic                enc_dec,
    input  logic                readData,
    output logic                ldKey,
    output logic                doneKey,
    output logic                ldData,
    output logic                doneData,
    output logic [2*N-1:0]      cipher
);
    localparam logic [61:0] Z2 = 62'b10101111011100000011010010011000101000010001111110010110110011;

    typedef enum logic [1:0] {KIDLE, KEXP, KREADY} kstate_t;
    typedef enum logic [1:0] {DIDLE, RUN, DONE} dstate_t;

    kstate_t       kstate;
    dstate_t       dstate;
    logic [N-1:0]  rk [T];
    logic [Co-1:0] ki, rnd, rk_idx;
    logic [N-1:0]  x, y, rkq, tmp, rk_new, x_n, y_n;
    logic          enc, key_go, data_go;

    function automatic logic [N-1:0] rol(input logic [N-1:0] a, input int s);
        return (a << s) | (a >> (N - s));
    endfunction

    function automatic logic [N-1:0] f(input logic [N-1:0] a);
        return (rol(a, 1) & rol(a, 8)) ^ rol(a, 2);
    endfunction

    // key load wins over a simultaneous data load; rekey waits for the running block
    assign key_go  = newKey && kstate != KEXP && dstate != RUN;
    assign data_go = newData && doneKey && !key_go && dstate == DIDLE;

    assign tmp    = rol(rk[ki + Co'(2)], N - 3) ^ rol(rol(rk[ki + Co'(2)], N - 3), N - 1);
    assign rk_new = ~rk[ki] ^ tmp ^ {{(N-1){1'b0}}, Z2[Co'(61) - ki]} ^ N'(3);

    // the round key is fetched into rkq one cycle ahead of the round that uses it
    assign rk_idx = enc ? rnd : Co'(T - 1) - rnd;
    assign x_n    = enc ? y ^ f(x) ^ rkq : y;
    assign y_n    = enc ? x : x ^ f(y) ^ rkq;

    always_ff @(posedge clk) begin
        ldKey  <= 1'b0;
        ldData <= 1'b0;
        if (nR) begin
            kstate   <= KIDLE;
            dstate   <= DIDLE;
            doneKey  <= 1'b0;
            doneData <= 1'b0;
            cipher   <= '0;
            ki       <= '0;
            rnd      <= '0;
            x        <= '0;
            y        <= '0;
            rkq      <= '0;
            enc      <= 1'b0;
            for (int i = 0; i < T; i++) rk[i] <= '0;
        end else begin
            if (key_go) begin
                kstate  <= KEXP;
                ldKey   <= 1'b1;
                doneKey <= 1'b0;
                ki      <= '0;
                for (int i = 0; i < M; i++) rk[i] <= key[i];
            end else if (kstate == KEXP) begin
                rk[ki + Co'(M)] <= rk_new;
                ki              <= ki + 1'b1;
                if (ki == Co'(T - M - 1)) kstate <= KREADY;
            end else if (kstate == KREADY) begin
                doneKey <= 1'b1;
            end
            if (data_go) begin
                dstate <= RUN;
                ldData <= 1'b1;
                rnd    <= '0;
                x      <= plain[2*N-1:N];
                y      <= plain[N-1:0];
                enc    <= enc_dec;
            end else if (dstate == RUN) begin
                rkq <= rk[rk_idx];
                rnd <= rnd + 1'b1;
                if (rnd != '0) begin
                    x <= x_n;
                    y <= y_n;
                end
                if (rnd == Co'(T)) begin
                    dstate   <= DONE;
                    doneData <= 1'b1;
                    cipher   <= {x_n, y_n};
                end
            end else if (dstate == DONE && readData) begin
                dstate   <= DIDLE;
                doneData <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_simon_64_96.sv
// tb_simon_64_96: scoreboard bench for the SIMON 64/96 core with a reference cipher model
module tb_simon_64_96;
    localparam logic [95:0] KEY = 96'h13121110_0B0A0908_03020100;
    localparam logic [61:0] Z2  = 62'b10101111011100000011010010011000101000010001111110010110110011;

    logic             clk = 1'b0;
    logic             nR, newKey, newData, enc_dec, readData;
    logic [2:0][31:0] key;
    logic [63:0]      plain, cipher;
    logic             ldKey, doneKey, ldData, doneData;

    int          total = 0, bad = 0, cyc = 0, n_ld = 0, n_ldk = 0, n_res = 0;
    logic        dd_prev = 1'b0;
    logic [63:0] exp_q [$];
    logic [63:0] last;
    logic [63:0] blk [5] = '{64'h6F7220676E696C63, 64'hA8D5F7DE0123FEDC, 64'h5BC92D014567BA98,
                             64'hF2B48D4589AB7654, 64'h567F11DECDEF3210};
    logic [63:0] res [5];

    always #5 clk = ~clk;

    simon_64_96 dut (
        .clk(clk), .nR(nR), .newKey(newKey), .key(key), .newData(newData), .plain(plain),
        .enc_dec(enc_dec), .readData(readData), .ldKey(ldKey), .doneKey(doneKey),
        .ldData(ldData), .doneData(doneData), .cipher(cipher)
    );

    function automatic logic [31:0] rl(input logic [31:0] a, input int s);
        return (a << s) | (a >> (32 - s));
    endfunction

    function automatic logic [63:0] simon_ref(input logic [95:0] k, input logic [63:0] p, input logic e);
        logic [31:0] ks [42];
        logic [31:0] a, b, t;
        for (int i = 0; i < 3; i++) ks[i] = k[32*i +: 32];
        for (int i = 0; i < 39; i++)
            ks[i+3] = 32'hFFFFFFFC ^ {31'b0, Z2[61-i]} ^ ks[i] ^ rl(ks[i+2], 29) ^ rl(ks[i+2], 28);
        a = p[63:32];
        b = p[31:0];
        for (int r = 0; r < 42; r++) begin
            if (e) begin
                t = a;
                a = b ^ ((rl(a, 1) & rl(a, 8)) ^ rl(a, 2)) ^ ks[r];
                b = t;
            end else begin
                t = b;
                b = a ^ ((rl(b, 1) & rl(b, 8)) ^ rl(b, 2)) ^ ks[41-r];
                a = t;
            end
        end
        return {a, b};
    endfunction

    function automatic logic sig(input int w);
        return w == 0 ? ldKey : w == 1 ? doneKey : w == 2 ? ldData : doneData;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        n_ld  += int'(ldData);
        n_ldk += int'(ldKey);
        if (doneData && !dd_prev) begin
            n_res++;
            chk("sb_avail", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("sb_result", cipher, exp_q.pop_front());
        end
        dd_prev = doneData;
    endtask

    task automatic wait_for(input int w, input int lim, input string tag);
        int n = 0;
        tick();
        while (!sig(w) && n < lim) begin
            tick();
            n++;
        end
        chk(tag, 64'(sig(w)), 64'd1);
    endtask

    task automatic load_key();
        int c;
        key    = KEY;
        newKey = 1'b1;
        wait_for(0, 100, "ldkey");
        newKey = 1'b0;
        c = cyc;
        tick();
        chk("ldkey_pulse", 64'(ldKey), 64'd0);
        chk("donekey_low", 64'(doneKey), 64'd0);
        wait_for(1, 100, "donekey");
        chk("key_lat", 64'(cyc - c), 64'd40);
    endtask

    task automatic start_block(input logic [63:0] p, input logic e, input logic [63:0] want, output int d);
        exp_q.push_back(want);
        plain   = p;
        enc_dec = e;
        newData = 1'b1;
        wait_for(2, 200, "lddata");
        d = cyc;
    endtask

    task automatic finish_block(input int d, input int rdel);
        wait_for(3, 100, "donedata");
        chk("data_lat", 64'(cyc - d), 64'd43);
        last = cipher;
        repeat (rdel) tick();
        readData = 1'b1;
        tick();
        readData = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int d, n0, r0, k0, chg;
        logic [63:0] held;
        nR = 1'b1; newKey = 1'b0; newData = 1'b0; enc_dec = 1'b0; readData = 1'b0;
        key = '0; plain = '0;
        repeat (3) tick();
        chk("rst_flags", 64'({ldKey, doneKey, ldData, doneData}), 64'd0);
        chk("rst_cipher", cipher, 64'd0);
        nR = 1'b0;
        load_key();

        // encrypt known answer, newData left high through the hold window
        start_block(64'h6F7220676E696C63, 1'b1, 64'h5CA2E27F111A8FC8, d);
        tick();
        chk("lddata_pulse", 64'(ldData), 64'd0);
        wait_for(3, 100, "donedata");
        chk("enc_lat", 64'(cyc - d), 64'd43);
        chk("kat_enc", cipher, 64'h5CA2E27F111A8FC8);
        held = cipher;
        n0   = n_ld;
        chg  = 0;
        repeat (100) begin
            tick();
            if (cipher !== held || !doneData) chg++;
        end
        chk("hold_stable", 64'(chg), 64'd0);
        chk("hold_noreload", 64'(n_ld - n0), 64'd0);
        newData  = 1'b0;
        readData = 1'b1;
        tick();
        readData = 1'b0;
        chk("rd_drop", 64'(doneData), 64'd0);
        chk("rd_cipher_kept", cipher, 64'h5CA2E27F111A8FC8);

        // decrypt known answer, readData pulsed while running must be ignored
        start_block(64'h5CA2E27F111A8FC8, 1'b0, 64'h6F7220676E696C63, d);
        newData  = 1'b0;
        readData = 1'b1;
        repeat (10) tick();
        readData = 1'b0;
        finish_block(d, 3);
        chk("kat_dec", last, 64'h6F7220676E696C63);

        // stream of five blocks with newData held high
        n0 = n_ld;
        r0 = n_res;
        for (int i = 0; i < 5; i++) begin
            start_block(blk[i], 1'b1, simon_ref(KEY, blk[i], 1'b1), d);
            newData = (i < 4);
            finish_block(d, 3);
            res[i] = last;
        end
        chk("stream_ld", 64'(n_ld - n0), 64'd5);
        chk("stream_res", 64'(n_res - r0), 64'd5);
        for (int i = 0; i < 5; i++) begin
            start_block(res[i], 1'b0, blk[i], d);
            newData = 1'b0;
            finish_block(d, 1);
        end

        // rekey with the same key, then another block
        load_key();
        start_block(blk[2], 1'b1, simon_ref(KEY, blk[2], 1'b1), d);
        newData = 1'b0;
        finish_block(d, 2);

        // newKey during RUN is deferred until the block completes
        start_block(blk[3], 1'b1, simon_ref(KEY, blk[3], 1'b1), d);
        newData = 1'b0;
        repeat (5) tick();
        newKey = 1'b1;
        k0 = n_ldk;
        wait_for(3, 100, "donedata_rk");
        chk("rk_deferred", 64'(n_ldk - k0), 64'd0);
        chk("rk_lat", 64'(cyc - d), 64'd43);
        wait_for(0, 10, "ldkey_after_run");
        newKey   = 1'b0;
        readData = 1'b1;
        tick();
        readData = 1'b0;
        wait_for(1, 100, "donekey_rk");
        start_block(blk[4], 1'b1, simon_ref(KEY, blk[4], 1'b1), d);
        newData = 1'b0;
        finish_block(d, 0);

        // reset in the middle of a block aborts it
        start_block(blk[0], 1'b1, simon_ref(KEY, blk[0], 1'b1), d);
        newData = 1'b0;
        repeat (19) tick();
        nR = 1'b1;
        tick();
        chk("midrst_flags", 64'({ldKey, doneKey, ldData, doneData}), 64'd0);
        chk("midrst_cipher", cipher, 64'd0);
        chk("abort_q", 64'(exp_q.size()), 64'd1);
        void'(exp_q.pop_front());
        nR = 1'b0;
        load_key();
        start_block(64'h6F7220676E696C63, 1'b1, 64'h5CA2E27F111A8FC8, d);
        newData = 1'b0;
        finish_block(d, 0);
        chk("post_rst", last, 64'h5CA2E27F111A8FC8);

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/simon_64_96.md
# simon_64_96

Iterative SIMON 64/96 block-cipher core: 64-bit block, 96-bit key, 42 rounds, one round per clock. It expands a loaded key into a stored round-key table. It then encrypts or decrypts one block at a time under a newX/ldX/doneX/readData handshake. It sits between a host-side stream controller and the data path that consumes cipher words.

## Interface
- N, 32: word size in bits (block = 2N).
- M, 3: key words.
- T, 42: number of rounds / round keys.
- Co, 6: round-counter width (must hold T-1).
- clk  in  1: single clock; all logic on the rising edge.
- nR  in  1: reset, synchronous, active-high (despite the name).
- newKey  in  1: request to load `key`.
- key  in  M×N packed (key[M-1:0][N-1:0]): key[0] = k0 (least significant word), key[2] = k2.
- newData  in  1: request to load `plain`.
- plain  in  2N: input block; [2N-1:N] = x (left word), [N-1:0] = y (right word).
- enc_dec  in  1: 1 = encrypt, 0 = decrypt; sampled at the data load.
- readData  in  1: host acknowledges `cipher`.
- ldKey  out  1: one-cycle pulse when the key is captured.
- doneKey  out  1: level; the round-key table is valid.
- ldData  out  1: one-cycle pulse when `plain` is captured.
- doneData  out  1: level; `cipher` is valid.
- cipher  out  2N: result block, same x|y packing as `plain`.

## Operation
- The key engine has states KIDLE, KEXP and KREADY.
  - KIDLE/KREADY to KEXP: taken when newKey=1 and the data engine is not in RUN. That cycle stores rk[0..2]=key[0..2], pulses ldKey and clears doneKey.
  - KEXP computes one round key per cycle, for i = 0..T-M-1:
    - tmp = ROR3(rk[i+2]) ^ ROR1(rk[i+1]) is not used; the correct form is tmp = ROR3(rk[i+2]) ^ ROR1(ROR3(rk[i+2])).
    - rk[i+3] = ~rk[i] ^ tmp ^ z2[i mod 62] ^ 3. Here `~` is a 32-bit NOT, and the constant is XORed into the low bits.
  - z2 = 10101111011100000011010010011000101000010001111110010110110011, with index 0 the leftmost bit.
  - KEXP takes T-M = 39 cycles, then goes to KREADY and sets doneKey=1. doneKey holds until the next key load or reset.
- The data engine has states DIDLE, RUN and DONE.
  - DIDLE to RUN: taken when newData=1, doneKey=1 and the key engine is not in KEXP. That cycle latches x, y and enc_dec, pulses ldData and resets the round counter.
  - Round function: f(a) = (ROL1(a) & ROL8(a)) ^ ROL2(a).
  - Encrypt round r = 0..T-1: (x,y) ← (y ^ f(x) ^ rk[r], x).
  - Decrypt round r = T-1..0: (x,y) ← (y, x ^ f(y) ^ rk[r]).
  - After T rounds the engine goes to DONE: cipher = {x,y} and doneData=1.
  - DONE to DIDLE: taken the cycle after readData=1 is sampled. doneData drops, and `cipher` keeps its value.
- newData held high past the load does not cause a reload while in RUN or DONE. A new load occurs only from DIDLE.
- newKey during RUN is deferred: it is acted on once the data engine leaves RUN, and only if still asserted.

## Timing
- Reset: every state goes to idle, ldKey=ldData=doneKey=doneData=0, cipher=0, and the key table is cleared.
- Key latency: ldKey in cycle c, doneKey=1 from cycle c+40.
- Data latency: ldData in cycle d, doneData=1 from cycle d+T+1 = d+43. One round runs per cycle, d+1..d+42.
- readData sampled 1 in cycle e gives doneData=0 from cycle e+1. The earliest next ldData is cycle e+1.
- readData while not in DONE is ignored.
- If newKey and newData are both requested from idle in the same cycle, the key load wins. The data waits for doneKey.
- Reset asserted mid-operation aborts immediately. No partial result is ever flagged valid.

## Test plan
- Encrypt known answer:
  - Stimulus: key = {13121110, 0B0A0908, 03020100}, plain = 6F7220676E696C63, enc_dec=1.
  - Required: cipher = 5CA2E27F111A8FC8, ldKey/ldData are single-cycle pulses, and latencies are 40 and 43 cycles.
- Decrypt known answer: same key, plain = 5CA2E27F111A8FC8, enc_dec=0 → cipher = 6F7220676E696C63.
- Stream of 5 blocks (6F7220676E696C63, A8D5F7DE0123FEDC, 5BC92D014567BA98, F2B48D4589AB7654, 567F11DECDEF3210):
  - Keep newData high and raise readData 3 cycles after each doneData.
  - Required: exactly 5 ldData pulses and 5 results; each result decrypts back to its input.
- Handshake hold: leave readData low for 100 cycles → doneData and cipher stay stable, and no second ldData occurs.
- Rekey:
  - Load the same key again after the first block → doneKey drops for 40 cycles, then the next block still gives a correct result.
  - Assert newKey during RUN → the current block completes correctly before ldKey pulses.
- Reset mid-round (cycle d+20) → all outputs are 0 next cycle, and after a re-load the result is correct.
